// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 pipeline constants and types: icodes, stat codes, register IDs,
// and the W pipeline register layout.
package writeback_regfile_pkg;
  typedef logic [63:0] word_t;
  typedef logic [3:0]  reg_id_t;

  localparam reg_id_t RNONE = 4'hF;
  localparam int      RF_N  = 15;

  localparam logic [3:0] I_HALT   = 4'd0,  I_NOP   = 4'd1,  I_RRMOVQ = 4'd2,
                         I_IRMOVQ = 4'd3,  I_RMMOVQ = 4'd4, I_MRMOVQ = 4'd5,
                         I_OPQ    = 4'd6,  I_JXX   = 4'd7,  I_CALL   = 4'd8,
                         I_RET    = 4'd9,  I_PUSHQ = 4'd10, I_POPQ   = 4'd11;

  localparam logic [3:0] S_AOK = 4'd1, S_HLT = 4'd2, S_ADR = 4'd3, S_INS = 4'd4;

  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    reg_id_t    dst_e;
    reg_id_t    dst_m;
    word_t      val_e;
    word_t      val_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{stat: S_AOK, icode: I_NOP, dst_e: RNONE,
                                  dst_m: RNONE, val_e: 64'd0, val_m: 64'd0};

  // Anything other than AOK stops the machine; unknown codes behave as INS.
  function automatic logic stat_halts(input logic [3:0] s);
    return s != S_AOK;
  endfunction
endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus: M-stage inputs, W controls, decode read ports, W exports.
interface writeback_regfile_if;
  import writeback_regfile_pkg::*;
  logic       W_stall, W_bubble;
  logic [3:0] m_stat, M_icode;
  reg_id_t    M_dstE, M_dstM;
  word_t      M_valE, m_valM;
  reg_id_t    d_srcA, d_srcB;
  word_t      d_rvalA, d_rvalB;
  logic [3:0] W_stat, W_icode;
  reg_id_t    W_dstE, W_dstM;
  word_t      W_valE, W_valM;
  logic       halted;

  modport master (
    output W_stall, W_bubble, m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
           d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted
  );
  modport slave (
    input  W_stall, W_bubble, m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
           d_srcA, d_srcB,
    output d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted
  );
endinterface

// File: rtl/writeback_regfile_rf.sv
// 15x64 register file, two combinational read ports, two write ports (M wins).
// Optional same-cycle write-to-read bypass under `WB_READ_BYPASS_EN.
module regfile_2r2w
  import writeback_regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    we_e,
  input  reg_id_t dst_e,
  input  word_t   val_e,
  input  logic    we_m,
  input  reg_id_t dst_m,
  input  word_t   val_m,
  input  reg_id_t src_a,
  input  reg_id_t src_b,
  output word_t   rval_a,
  output word_t   rval_b
);
  logic [RF_N-1:0][63:0] regs_q, regs_d;
  logic wr_e, wr_m;

  assign wr_e = we_e && (dst_e != RNONE);
  assign wr_m = we_m && (dst_m != RNONE);

  always_comb begin
    regs_d = regs_q;
    if (wr_e) regs_d[dst_e] = val_e;
    if (wr_m) regs_d[dst_m] = val_m;   // applied last so popq %rsp keeps valM
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  function automatic word_t rd_port(input reg_id_t src,
                                    input logic [RF_N-1:0][63:0] regs);
    word_t r;
    r = (src == RNONE) ? 64'd0 : regs[src];
`ifdef WB_READ_BYPASS_EN
    if (wr_m && dst_m == src)      r = val_m;
    else if (wr_e && dst_e == src) r = val_e;
`endif
    return r;
  endfunction

  assign rval_a = rd_port(src_a, regs_q);
  assign rval_b = rd_port(src_b, regs_q);
endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: W pipeline register, sticky halt, and register file.
// Build option: WB_READ_BYPASS_EN forwards the current write to decode reads.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input logic              clk,
  input logic              reset,
  writeback_regfile_if.slave wb
);
  w_reg_t w_q, w_d, m_in;
  logic   halted_q, halted_d;
  logic   wr_ok;

  assign m_in = '{stat: wb.m_stat, icode: wb.M_icode, dst_e: wb.M_dstE,
                  dst_m: wb.M_dstM, val_e: wb.M_valE, val_m: wb.m_valM};

  always_comb begin
    w_d = w_q;
    if (!halted_q && !wb.W_stall) w_d = wb.W_bubble ? W_BUBBLE : m_in;
  end

  assign halted_d = halted_q || stat_halts(w_q.stat);
  // Reset gating also keeps the bypass path from showing a discarded write.
  assign wr_ok    = !reset && !halted_q && !stat_halts(w_q.stat);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      w_q      <= w_d;
      halted_q <= halted_d;
    end
  end

  regfile_2r2w u_rf (
    .clk   (clk),
    .reset (reset),
    .we_e  (wr_ok),
    .dst_e (w_q.dst_e),
    .val_e (w_q.val_e),
    .we_m  (wr_ok),
    .dst_m (w_q.dst_m),
    .val_m (w_q.val_m),
    .src_a (wb.d_srcA),
    .src_b (wb.d_srcB),
    .rval_a(wb.d_rvalA),
    .rval_b(wb.d_rvalB)
  );

  assign wb.W_stat  = w_q.stat;
  assign wb.W_icode = w_q.icode;
  assign wb.W_dstE  = w_q.dst_e;
  assign wb.W_dstM  = w_q.dst_m;
  assign wb.W_valE  = w_q.val_e;
  assign wb.W_valM  = w_q.val_m;
  assign wb.halted  = halted_q;
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL: W_stall  input  1  hold W pipeline register contents.
REQ-004 SHALL: W_bubble  input  1  load NOP bubble into W register.
REQ-005 SHALL: m_stat, M_icode  input  4 each  status and icode from memory stage.
REQ-006 SHALL: M_dstE, M_dstM  input  4 each  destination register IDs; 4'hF = RNONE.
REQ-007 SHALL: M_valE, m_valM  input  64 each  ALU result and memory read data.
REQ-008 SHALL: d_srcA, d_srcB  input  4 each  decode-stage read addresses.
REQ-009 SHALL: d_rvalA, d_rvalB  output  64 each  register read data.
REQ-010 SHALL: W_stat, W_icode, W_dstE, W_dstM  output  4 each  W register fields, exported for forwarding and control.
REQ-011 SHALL: W_valE, W_valM  output  64 each  W register data fields.
REQ-012 SHALL: halted  output  1  sticky: processor has stopped.

Function
REQ-013 SHALL: W register load M-stage values each cycle when W_stall=0 and W_bubble=0.
REQ-014 SHALL: W_stall=1 hold W register; W_stall takes priority over W_bubble when both are asserted.
REQ-015 SHALL: bubble load stat=AOK(1), icode=NOP(1), dstE=dstM=4'hF, valE=valM=0.
REQ-016 SHALL: register file = 15 x 64-bit entries, IDs 0..14; ID 4'hF is never written and always reads 0.
REQ-017 SHALL: on each rising edge with W_stat=AOK and halted=0, write W_valE to W_dstE and W_valM to W_dstM (each only if not 4'hF).
REQ-018 SHALL: W_dstE == W_dstM != 4'hF, so M port wins (popq %rsp semantics); exactly one write lands.
REQ-019 SHALL: reads combinational, zero latency; without bypass, returns the pre-edge register contents.
REQ-020 SHALL: W_stat in {HLT(2), ADR(3), INS(4)} suppress that cycle's writes and set halted on the same edge.
REQ-021 SHALL: once halted=1, all register writes are blocked and the W register freezes until reset, regardless of W_stall/W_bubble.
REQ-022 SHALL: W_stat values outside 1..4 be treated as INS: halt and suppress writes.

Reset
REQ-023 SHALL: reset=1 clear all 15 registers to 0, load W register with bubble (REQ-015), clear halted.
REQ-024 SHALL: reset be top priority over stall, bubble, writes and halt; on a mid-run reset, the pending W write is discarded.
REQ-025 SHALL: outputs show reset values from the first edge after reset is asserted.

Configuration
REQ-026 SHALL: macro WB_READ_BYPASS_EN defined: d_rvalA/B return the W write data in the same cycle when the read ID matches a write being performed; M port has priority per REQ-018.
REQ-027 SHALL: macro undefined: no bypass; same-cycle reads return the old value and the decode forwarding logic covers the hazard.

Structure
REQ-028 SHALL: shared package hold the icode constants (NOP=1, HALT=0, MRMOVQ=5, POPQ=11, etc.), stat codes AOK/HLT/ADR/INS, RNONE=4'hF, and the 64-bit word type.
REQ-029 SHALL: register array be sub-module regfile_2r2w (two read ports, two write ports, M-priority); the W register and halt logic stay in writeback_regfile.

Verification
REQ-030 SHALL: reset, then M_dstE=3, M_valE=64'h55 (AOK) -> after 2 edges d_srcA=3 reads 64'h55; d_srcB=15 reads 0.
REQ-031 SHALL: M_dstE=M_dstM=4, valE=64'h10, valM=64'h20 -> register 4 = 64'h20.
REQ-032 SHALL: W_stall=1 and W_bubble=1 while W holds dstE=2/valE=7 -> W fields unchanged; register 2 = 7 after the next edge.
REQ-033 SHALL: m_stat=ADR with dstE=5 -> halted=1 one edge after W loads; register 5 unchanged; later AOK writes ignored until reset.
REQ-034 SHALL: with WB_READ_BYPASS_EN, W_dstM=6/valM=64'hAB and d_srcA=6 in the same cycle -> d_rvalA=64'hAB; without the macro -> old value.
REQ-035 SHALL: reset asserted while W holds a valid write -> register not written; all registers 0; W_icode=1; halted=0.
